// File: rtl/ex_operand_pkg.sv
// Shared codes for the ID->EX operand scheduler: ALU source selects, forwarding
// selects, opcode/func values and the hazard FSM state type.
package ex_operand_pkg;

    localparam logic [2:0] SRC_REG    = 3'd0;
    localparam logic [2:0] SRC_ZIMM   = 3'd1;
    localparam logic [2:0] SRC_SIMM   = 3'd2;
    localparam logic [2:0] SRC_VSHIFT = 3'd3;
    localparam logic [2:0] SRC_SHAMT  = 3'd4;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT
    } dst_sel_t;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } hz_state_t;

endpackage

// File: rtl/ex_operand_decode.sv
// Combinational opcode/func decode: ALU source select, destination field,
// which source registers are actually read, and whether the op is a load.
module ex_operand_decode
    import ex_operand_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [2:0] src,
    output dst_sel_t   dst_sel,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       is_load
);

    always_comb begin
        src     = SRC_REG;
        dst_sel = DST_NONE;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dst_sel = DST_RD;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                case (func)
                    // Constant shifts take the amount from shamt, so rs is not read.
                    F_SLL, F_SRL, F_SRA: begin
                        src     = SRC_SHAMT;
                        uses_rs = 1'b0;
                    end
                    F_SLLV, F_SRLV, F_SRAV: src = SRC_VSHIFT;
                    default:                src = SRC_REG;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                src     = SRC_ZIMM;
                dst_sel = DST_RT;
                uses_rs = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                src     = SRC_SIMM;
                dst_sel = DST_RT;
                uses_rs = 1'b1;
            end
            OP_LW: begin
                src     = SRC_SIMM;
                dst_sel = DST_RT;
                uses_rs = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                src     = SRC_SIMM;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_operand_ctrl.sv
// ID->EX operand scheduler: decode, EX/MEM destination tracking, forwarding
// selects, hazard stalls and EX-stage registers. Optional macro: OPERAND_FWD_EN.
module ex_operand_ctrl
    import ex_operand_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned SRC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_func,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [SRC_W-1:0] ex_src_ctrl,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [REG_W-1:0] ex_dst,
    output logic             ex_mem_read
);

    logic [2:0]       id_src;
    dst_sel_t         id_dst_sel;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_load;
    logic [REG_W-1:0] id_dst;
    // WB needs no tracking: the register file writes before it is read.
    logic [REG_W-1:0] mem_dst;
    hz_state_t        state;
    logic             match_ex_a, match_ex_b, match_mem_a, match_mem_b;
    logic             hazard;
    logic             bubble;

    ex_operand_decode u_decode (
        .opcode  (id_opcode),
        .func    (id_func),
        .src     (id_src),
        .dst_sel (id_dst_sel),
        .uses_rs (id_uses_rs),
        .uses_rt (id_uses_rt),
        .is_load (id_is_load)
    );

    always_comb begin
        id_dst = '0;
        case (id_dst_sel)
            DST_RD:  id_dst = id_rd;
            DST_RT:  id_dst = id_rt;
            default: id_dst = '0;
        endcase
    end

    // ex_dst/mem_dst are 0 for bubbles, and register 0 is excluded explicitly.
    assign match_ex_a  = id_valid && id_uses_rs && (id_rs != '0) && (id_rs == ex_dst);
    assign match_ex_b  = id_valid && id_uses_rt && (id_rt != '0) && (id_rt == ex_dst);
    assign match_mem_a = id_valid && id_uses_rs && (id_rs != '0) && (id_rs == mem_dst);
    assign match_mem_b = id_valid && id_uses_rt && (id_rt != '0) && (id_rt == mem_dst);

`ifdef OPERAND_FWD_EN
    logic [1:0] fwd_a_next, fwd_b_next;

    assign hazard = ex_mem_read && (match_ex_a || match_ex_b);
    assign stall  = hazard && !flush && (state == ST_RUN);

    always_comb begin
        fwd_a_next = FWD_REG;
        fwd_b_next = FWD_REG;
        if (match_ex_a)       fwd_a_next = FWD_EXMEM;
        else if (match_mem_a) fwd_a_next = FWD_MEMWB;
        if (match_ex_b)       fwd_b_next = FWD_EXMEM;
        else if (match_mem_b) fwd_b_next = FWD_MEMWB;
    end
`else
    logic [1:0] hold_cnt;

    assign hazard   = match_ex_a || match_ex_b || match_mem_a || match_mem_b;
    assign stall    = !flush && ((state == ST_RUN) ? hazard : (hold_cnt != 2'd0));
    assign ex_fwd_a = FWD_REG;
    assign ex_fwd_b = FWD_REG;
`endif

    assign bubble = stall || flush || !id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            mem_dst     <= '0;
            ex_valid    <= 1'b0;
            ex_src_ctrl <= '0;
            ex_dst      <= '0;
            ex_mem_read <= 1'b0;
`ifdef OPERAND_FWD_EN
            ex_fwd_a    <= FWD_REG;
            ex_fwd_b    <= FWD_REG;
`else
            hold_cnt    <= 2'd0;
`endif
        end else begin
            mem_dst <= ex_dst;
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_src_ctrl <= '0;
                ex_dst      <= '0;
                ex_mem_read <= 1'b0;
`ifdef OPERAND_FWD_EN
                ex_fwd_a    <= FWD_REG;
                ex_fwd_b    <= FWD_REG;
`endif
            end else begin
                ex_valid    <= 1'b1;
                ex_src_ctrl <= SRC_W'(id_src);
                ex_dst      <= id_dst;
                ex_mem_read <= id_is_load;
`ifdef OPERAND_FWD_EN
                ex_fwd_a    <= fwd_a_next;
                ex_fwd_b    <= fwd_b_next;
`endif
            end

`ifdef OPERAND_FWD_EN
            case (state)
                ST_RUN:   if (stall) state <= ST_STALL;
                default:  state <= ST_RUN;
            endcase
`else
            // hold_cnt is the number of stall cycles still owed after the current one.
            case (state)
                ST_RUN: begin
                    if (stall) begin
                        state    <= ST_STALL;
                        hold_cnt <= (match_ex_a || match_ex_b) ? 2'd1 : 2'd0;
                    end
                end
                default: begin
                    if (flush || (hold_cnt == 2'd0)) begin
                        state    <= ST_RUN;
                        hold_cnt <= 2'd0;
                    end else begin
                        hold_cnt <= hold_cnt - 2'd1;
                    end
                end
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Scoreboard bench for ex_operand_ctrl; expectations follow OPERAND_FWD_EN if defined.
module tb_ex_operand_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_func;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush;
    logic       stall;
    logic       ex_valid;
    logic [2:0] ex_src_ctrl;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic [4:0] ex_dst;
    logic       ex_mem_read;

    ex_operand_ctrl #(.REG_W(5), .SRC_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_func     (id_func),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .flush       (flush),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_src_ctrl (ex_src_ctrl),
        .ex_fwd_a    (ex_fwd_a),
        .ex_fwd_b    (ex_fwd_b),
        .ex_dst      (ex_dst),
        .ex_mem_read (ex_mem_read)
    );

    always #5 clk = ~clk;

`ifdef OPERAND_FWD_EN
    localparam int unsigned RAW_STALLS = 0;
    localparam int unsigned LU_STALLS  = 1;
    localparam int unsigned FWD_ON     = 1;
`else
    localparam int unsigned RAW_STALLS = 2;
    localparam int unsigned LU_STALLS  = 2;
    localparam int unsigned FWD_ON     = 0;
`endif

    typedef struct packed {
        logic [2:0] src;
        logic [4:0] dst;
        logic       urs;
        logic       urt;
        logic       ld;
    } dec_t;

    typedef struct packed {
        logic       v;
        logic [2:0] src;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [4:0] dst;
        logic       ld;
    } ex_t;

    ex_t        exq[$];
    logic [4:0] m_ex_dst, m_mem_dst;
    logic       m_ex_ld;
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] rt, input logic [4:0] rd);
        dec_t d;
        d = '0;
        if (op == 6'h00) begin
            d.dst = rd;
            d.urt = 1'b1;
            if (fn inside {6'h00, 6'h02, 6'h03}) d.src = 3'd4;
            else begin
                d.urs = 1'b1;
                d.src = (fn inside {6'h04, 6'h06, 6'h07}) ? 3'd3 : 3'd0;
            end
        end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
            d.src = 3'd1; d.dst = rt; d.urs = 1'b1;
        end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23}) begin
            d.src = 3'd2; d.dst = rt; d.urs = 1'b1; d.ld = (op == 6'h23);
        end else if (op == 6'h2B) begin
            d.src = 3'd2; d.urs = 1'b1; d.urt = 1'b1;
        end else if (op inside {6'h04, 6'h05}) begin
            d.urs = 1'b1; d.urt = 1'b1;
        end
        return d;
    endfunction

    function automatic logic hit(input logic used, input logic [4:0] r, input logic [4:0] d);
        return used && (r != 5'd0) && (r == d);
    endfunction

    task automatic do_cycle(input logic v, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic fl, output logic stalled);
        dec_t d;
        ex_t  e, got;
        logic hz_ex, hz_mem, want_stall;
        id_valid = v; id_opcode = op; id_func = fn;
        id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
        #1;
        d      = ref_decode(op, fn, rt, rd);
        hz_ex  = v && (hit(d.urs, rs, m_ex_dst) || hit(d.urt, rt, m_ex_dst));
        hz_mem = v && (hit(d.urs, rs, m_mem_dst) || hit(d.urt, rt, m_mem_dst));
`ifdef OPERAND_FWD_EN
        want_stall = hz_ex && m_ex_ld && !fl;
`else
        want_stall = (hz_ex || hz_mem) && !fl;
`endif
        check("stall", {31'b0, stall}, {31'b0, want_stall});
        e = '0;
        if (!(want_stall || fl || !v)) begin
            e.v   = 1'b1;
            e.src = d.src;
            e.dst = d.dst;
            e.ld  = d.ld;
            if (FWD_ON != 0) begin
                e.fa = hit(d.urs, rs, m_ex_dst) ? 2'd1 : (hit(d.urs, rs, m_mem_dst) ? 2'd2 : 2'd0);
                e.fb = hit(d.urt, rt, m_ex_dst) ? 2'd1 : (hit(d.urt, rt, m_mem_dst) ? 2'd2 : 2'd0);
            end
        end
        exq.push_back(e);
        @(posedge clk);
        #1;
        got = exq.pop_front();
        check("ex_valid",    {31'b0, ex_valid},    {31'b0, got.v});
        check("ex_src_ctrl", {29'b0, ex_src_ctrl}, {29'b0, got.src});
        check("ex_fwd_a",    {30'b0, ex_fwd_a},    {30'b0, got.fa});
        check("ex_fwd_b",    {30'b0, ex_fwd_b},    {30'b0, got.fb});
        check("ex_dst",      {27'b0, ex_dst},      {27'b0, got.dst});
        check("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, got.ld});
        m_mem_dst = m_ex_dst;
        m_ex_dst  = got.dst;
        m_ex_ld   = got.ld;
        stalled   = want_stall;
    endtask

    // Presents one instruction, holding it in ID while the model expects a stall.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic fl,
                         output int unsigned n);
        logic s;
        n = 0;
        s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, op, fn, rs, rt, rd, fl, s);
            if (!s) break;
            n++;
        end
        check("stall_released", {31'b0, s}, 32'd0);
    endtask

    task automatic r_op(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, output int unsigned n);
        issue(6'h00, fn, rs, rt, rd, 1'b0, n);
    endtask

    task automatic i_op(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs,
                        output int unsigned n);
        issue(op, 6'h15, rs, rt, 5'd31, 1'b0, n);
    endtask

    task automatic drain();
        int unsigned n;
        repeat (3) r_op(6'h00, 5'd0, 5'd0, 5'd0, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic        s;
        reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_func = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0;
        m_ex_dst = '0; m_mem_dst = '0; m_ex_ld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_ex_src",   {29'b0, ex_src_ctrl}, 32'd0);
        check("rst_ex_dst",   {27'b0, ex_dst}, 32'd0);
        check("rst_ex_mem",   {31'b0, ex_mem_read}, 32'd0);
        check("rst_stall",    {31'b0, stall}, 32'd0);
        reset = 1'b0;

        // add $3,$1,$2 ; sub $4,$3,$5
        r_op(6'h20, 5'd3, 5'd1, 5'd2, n);
        r_op(6'h22, 5'd4, 5'd3, 5'd5, n);
        check("raw_stall_cycles", n, RAW_STALLS);
        check("raw_fwd_a", {30'b0, ex_fwd_a}, FWD_ON);
        drain();

        // add $3 ; nop ; or $6,$7,$3  then  add $3 ; add $3 ; or
        r_op(6'h20, 5'd3, 5'd1, 5'd2, n);
        r_op(6'h00, 5'd0, 5'd0, 5'd0, n);
        r_op(6'h25, 5'd6, 5'd7, 5'd3, n);
        check("mem_fwd_b", {30'b0, ex_fwd_b}, 2 * FWD_ON);
        drain();
        r_op(6'h20, 5'd3, 5'd1, 5'd2, n);
        r_op(6'h20, 5'd3, 5'd1, 5'd2, n);
        r_op(6'h25, 5'd6, 5'd7, 5'd3, n);
        check("ex_prio_fwd_b", {30'b0, ex_fwd_b}, FWD_ON);
        drain();

        // lw $8 ; addi $9,$8,4
        i_op(6'h23, 5'd8, 5'd1, n);
        i_op(6'h08, 5'd9, 5'd8, n);
        check("lu_stall_cycles", n, LU_STALLS);
        check("lu_src", {29'b0, ex_src_ctrl}, 32'd2);
        check("lu_fwd_a", {30'b0, ex_fwd_a}, 2 * FWD_ON);

        // sll $2,$3,4 with rs=$9 (dst of addi) ; sllv ; ori ; addi
        r_op(6'h00, 5'd2, 5'd9, 5'd3, n);
        check("sll_stalls", n, 32'd0);
        check("sll_src", {29'b0, ex_src_ctrl}, 32'd4);
        check("sll_fwd_a", {30'b0, ex_fwd_a}, 32'd0);
        r_op(6'h04, 5'd5, 5'd2, 5'd6, n);
        check("sllv_src", {29'b0, ex_src_ctrl}, 32'd3);
        i_op(6'h0D, 5'd7, 5'd1, n);
        check("ori_src", {29'b0, ex_src_ctrl}, 32'd1);
        i_op(6'h08, 5'd10, 5'd11, n);
        check("addi_src", {29'b0, ex_src_ctrl}, 32'd2);
        drain();

        // writes to $0 then reads of $0
        i_op(6'h08, 5'd0, 5'd1, n);
        r_op(6'h20, 5'd5, 5'd0, 5'd0, n);
        check("zero_stalls", n, 32'd0);
        check("zero_fwd_a", {30'b0, ex_fwd_a}, 32'd0);
        drain();

        // lw hazard killed by flush in the same cycle
        i_op(6'h23, 5'd8, 5'd1, n);
        issue(6'h08, 6'h00, 5'd8, 5'd9, 5'd0, 1'b1, n);
        check("flush_valid", {31'b0, ex_valid}, 32'd0);

        // branches, stores, unknown opcode, plain R op
        i_op(6'h23, 5'd4, 5'd1, n);
        issue(6'h04, 6'h00, 5'd4, 5'd5, 5'd0, 1'b0, n);
        issue(6'h2B, 6'h00, 5'd1, 5'd4, 5'd0, 1'b0, n);
        issue(6'h3F, 6'h00, 5'd4, 5'd4, 5'd4, 1'b0, n);
        r_op(6'h2A, 5'd6, 5'd4, 5'd4, n);

        // random mix over a small register set to provoke hazards
        for (int i = 0; i < 80; i++) begin
            logic [5:0] op, fn;
            logic [4:0] a, b, c;
            int unsigned k;
            k  = $urandom_range(0, 9);
            a  = 5'($urandom_range(0, 3));
            b  = 5'($urandom_range(0, 3));
            c  = 5'($urandom_range(0, 3));
            op = 6'h00;
            fn = 6'h20;
            case (k)
                1: fn = 6'h00;
                2: fn = 6'h06;
                3: op = 6'h0E;
                4: op = 6'h09;
                5: op = 6'h23;
                6: op = 6'h2B;
                7: op = 6'h05;
                8: op = 6'h3F;
                9: fn = 6'h2A;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) do_cycle(1'b0, op, fn, a, b, c, 1'b0, s);
            else issue(op, fn, a, b, c, ($urandom_range(0, 7) == 0), n);
        end
        drain();

        // reset asserted while a load-use stall is active
        i_op(6'h23, 5'd10, 5'd1, n);
        id_valid = 1'b1; id_opcode = 6'h08; id_func = 6'h00;
        id_rs = 5'd10; id_rt = 5'd11; id_rd = 5'd0; flush = 1'b0;
        #1;
        check("midstall_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_stall",  {31'b0, stall}, 32'd0);
        check("midrst_valid",  {31'b0, ex_valid}, 32'd0);
        check("midrst_dst",    {27'b0, ex_dst}, 32'd0);
        check("midrst_mem",    {31'b0, ex_mem_read}, 32'd0);
        check("midrst_src",    {29'b0, ex_src_ctrl}, 32'd0);
        check("midrst_fwd",    {28'b0, ex_fwd_a, ex_fwd_b}, 32'd0);
        exq.delete();
        m_ex_dst = '0; m_mem_dst = '0; m_ex_ld = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_op(6'h08, 5'd11, 5'd10, n);
        check("post_rst_stalls", n, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
